// File: rtl/cpu_data_obi_buffer.sv
// cpu_data_obi_buffer: request FIFO with outstanding-transaction limit on the CPU data OBI port
package cpu_data_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cpu_data_obi_buffer
  import cpu_data_obi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  core_req_i,
  output obi_resp_t core_resp_o,
  output obi_req_t  bus_req_o,
  input  obi_resp_t bus_resp_i,
  output logic      idle_o,
  output logic      err_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = (CW > PW ? CW : PW) + 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } entry_t;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] bus_pend;
  logic [IW-1:0] inflight;
  logic          push, pop, rsp, spurious;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign inflight = IW'(fifo_cnt) + IW'(bus_pend);
  // grant looks only at registered occupancy, so bus gnt never reaches core gnt
  assign push     = rst_ni & core_req_i.req & (fifo_cnt < CW'(DEPTH)) & (inflight < IW'(MAX_OUTSTANDING));
  assign pop      = bus_req_o.req & bus_resp_i.gnt;
  assign rsp      = rst_ni & bus_resp_i.rvalid & (bus_pend != '0);
  assign spurious = bus_resp_i.rvalid & (bus_pend == '0);
  assign head     = mem[rptr];
  assign bus_req_o = '{req: rst_ni & (fifo_cnt != '0), we: head.we, be: head.be,
                       addr: head.addr, wdata: head.wdata};
  assign core_resp_o = '{gnt: push, rvalid: rsp, rdata: bus_resp_i.rdata};
  assign idle_o = ~rst_ni | ((fifo_cnt == '0) & (bus_pend == '0));
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      bus_pend <= '0;
      err_o    <= 1'b0;
    end else begin
      wptr     <= push ? inc(wptr) : wptr;
      rptr     <= pop ? inc(rptr) : rptr;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      bus_pend <= bus_pend + PW'(pop) - PW'(rsp);
      err_o    <= err_o | spurious;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= '{we: core_req_i.we, be: core_req_i.be, addr: core_req_i.addr, wdata: core_req_i.wdata};
  end
endmodule
